alm_vector: RTL and testbench
=============================

Name: alm_vector

Overview:
Serial-to-parallel bit collector. Samples the 1-bit input isenal on every rising iclk edge and assembles ANCHO consecutive samples into a word. It publishes each complete word on oValor, with a one-cycle oValido strobe. It sits behind a serial signal source and feeds downstream parallel logic that consumes oValor, optionally qualified by oValido.

Parameters:
ANCHO, 8, word width in bits (>= 2); also the number of samples per frame.
MSB_PRIMERO, 1, 1 = first sampled bit lands in oValor[ANCHO-1]; 0 = first sampled bit lands in oValor[0].

Ports:
iclk  input  1  system clock; all state changes on the rising edge.
irst_n  input  1  asynchronous active-low reset.
isenal  input  1  serial data bit, sampled every rising iclk edge.
oValor  output  ANCHO  last completed word; registered; holds between frames.
oValido  output  1  high for exactly one cycle when oValor has just been updated.

Behaviour:
- One clock domain (iclk). Reset is asynchronous and active-low (irst_n).
- Reset (irst_n=0, asynchronous assert):
  - shift register = 0, bit counter = 0, oValor = 0, oValido = 0.
  - Deassertion is sampled on iclk; the first rising edge with irst_n=1 captures bit 0 of a new frame.
- Internal state:
  - shift register sr[ANCHO-1:0].
  - bit counter cnt, width clog2(ANCHO), range 0..ANCHO-1.
- Every rising edge with irst_n=1:
  - MSB_PRIMERO=1: sr <= {sr[ANCHO-2:0], isenal}.
  - MSB_PRIMERO=0: sr <= {isenal, sr[ANCHO-1:1]}.
  - No enable input: capture is continuous, one bit per clock.
- Frame completion (cnt == ANCHO-1 at the edge):
  - oValor <= the shifted value including the current isenal bit (the same value sr takes on this edge).
  - oValido <= 1 and cnt <= 0 (wrap).
- Otherwise: cnt <= cnt+1, oValido <= 0, oValor unchanged.
- Latency: the last bit of a frame, sampled at edge N, appears on oValor after edge N (zero extra cycles); oValido is high during the cycle following edge N.
- Frames are back-to-back with no gap. The bit sampled immediately after a completion edge is bit 0 of the next frame.
- sr is not cleared at wrap; old bits shift out naturally.
- Reset mid-frame discards the partial frame. oValor returns to 0 and the count restarts at 0 after release.
- isenal must be stable around the rising edge (synchronous input). Synchronising asynchronous sources is the instantiating block's responsibility.

Decomposition:
- Shared package: ANCHO default constant (8) and a typedef for the ANCHO-bit word; no other types needed.
- No sub-module. Shift register, counter and output register fit in one module.

Test Plan:
- Reset: hold irst_n=0 with iclk toggling (period 100) -> oValor=8'h00, oValido=0. Assert irst_n asynchronously between edges -> outputs clear immediately.
- Single frame, MSB_PRIMERO=1: after release, drive isenal 1,0,1,1,0,0,1,0 on 8 edges -> oValor=8'hB2 after the 8th edge, oValido=1 for one cycle; oValor unchanged earlier.
- Back-to-back frames: 8 ones then 8 zeros -> oValor=8'hFF with oValido pulse, then 8'h00 exactly 8 cycles later with a second pulse; no missed or extra bits.
- Hold: after 8'hB2 is published, drive 7 further bits -> oValor stays 8'hB2 and oValido stays 0 for those 7 cycles.
- Reset mid-frame: drive 3 bits, pulse irst_n low, release, drive 0,1,0,1,0,1,0,1 -> oValor=8'h55 exactly 8 edges after release; oValor is 0 before that.
- LSB-first (MSB_PRIMERO=0): drive 1,0,1,1,0,0,1,0 -> oValor=8'h4D.

Source files
------------

// File: rtl/alm_vector_pkg.sv
// alm_vector_pkg: shared constants and types for the serial-to-parallel collector.
//   ANCHO_DEF - default word width / samples per frame
//   palabra_t - word type at the default width
package alm_vector_pkg;

  localparam int unsigned ANCHO_DEF = 8;

  typedef logic [ANCHO_DEF-1:0] palabra_t;

endpackage

// File: rtl/alm_vector.sv
// alm_vector: serial-to-parallel bit collector.
// Samples isenal on every rising iclk edge and assembles ANCHO consecutive
// samples into a word, published on oValor together with a one-cycle oValido
// strobe. Capture is continuous and frames are back-to-back.
//   iclk    - system clock, rising edge
//   irst_n  - asynchronous active-low reset
//   isenal  - serial data bit (must be synchronous to iclk)
//   oValor  - last completed word, held between frames
//   oValido - high for one cycle after oValor is updated
module alm_vector
  import alm_vector_pkg::*;
#(
  parameter int unsigned ANCHO       = ANCHO_DEF,
  parameter bit          MSB_PRIMERO = 1'b1
) (
  input  logic             iclk,
  input  logic             irst_n,
  input  logic             isenal,
  output logic [ANCHO-1:0] oValor,
  output logic             oValido
);

  localparam int unsigned      CW     = $clog2(ANCHO);
  localparam logic [CW-1:0]    ULTIMO = CW'(ANCHO - 1);

  logic [ANCHO-1:0] sr;
  logic [ANCHO-1:0] sr_sig;
  logic [CW-1:0]    cnt;

  // Next shift-register value, including the bit sampled on this edge; the
  // completed word is taken from here so the last bit lands with no extra delay.
  generate
    if (MSB_PRIMERO) begin : g_msb
      always_comb sr_sig = {sr[ANCHO-2:0], isenal};
    end else begin : g_lsb
      always_comb sr_sig = {isenal, sr[ANCHO-1:1]};
    end
  endgenerate

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      sr      <= '0;
      cnt     <= '0;
      oValor  <= '0;
      oValido <= 1'b0;
    end else begin
      sr <= sr_sig;
      if (cnt == ULTIMO) begin
        cnt     <= '0;
        oValor  <= sr_sig;
        oValido <= 1'b1;
      end else begin
        cnt     <= cnt + CW'(1);
        oValido <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alm_vector.sv
// tb_alm_vector: self-checking bench for alm_vector. Two instances share the
// serial input: one MSB-first, one LSB-first. Expected words are built from a
// per-frame list of sampled bits.
module tb_alm_vector;
  import alm_vector_pkg::*;

  localparam int unsigned W = ANCHO_DEF;

  logic     iclk = 1'b0;
  logic     irst_n;
  logic     isenal;
  palabra_t valor_m, valor_l;
  logic     valido_m, valido_l;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit       frame[$];
  palabra_t exp_m, exp_l;
  bit       exp_v;

  alm_vector #(.ANCHO(W), .MSB_PRIMERO(1'b1)) u_msb (
    .iclk(iclk), .irst_n(irst_n), .isenal(isenal),
    .oValor(valor_m), .oValido(valido_m)
  );

  alm_vector #(.ANCHO(W), .MSB_PRIMERO(1'b0)) u_lsb (
    .iclk(iclk), .irst_n(irst_n), .isenal(isenal),
    .oValor(valor_l), .oValido(valido_l)
  );

  always #50 iclk = ~iclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    frame.delete();
    exp_m = '0;
    exp_l = '0;
    exp_v = 1'b0;
  endtask

  task automatic model_bit(input bit b);
    int unsigned wm;
    int unsigned wl;
    frame.push_back(b);
    exp_v = 1'b0;
    if (frame.size() == W) begin
      wm = 0;
      wl = 0;
      for (int i = 0; i < W; i++) begin
        wm = wm * 2 + frame[i];          // first sample ends up most significant
        wl = wl + (int'(frame[i]) << i); // first sample ends up at bit 0
      end
      exp_m = palabra_t'(wm);
      exp_l = palabra_t'(wl);
      exp_v = 1'b1;
      frame.delete();
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_vm"}, 32'(valor_m),  32'(exp_m));
    check({tag, "_qm"}, 32'(valido_m), 32'(exp_v));
    check({tag, "_vl"}, 32'(valor_l),  32'(exp_l));
    check({tag, "_ql"}, 32'(valido_l), 32'(exp_v));
  endtask

  // Caller is always away from a rising edge when this is entered.
  task automatic step(input bit b, input string tag);
    isenal = b;
    @(posedge iclk);
    #10;
    model_bit(b);
    check_all(tag);
  endtask

  // Asynchronous reset pulse started between edges; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    irst_n = 1'b0;
    #5;
    model_reset();
    check_all({tag, "_async"});
    @(posedge iclk);
    #10;
    check_all({tag, "_held"});
    irst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    irst_n = 1'b0;
    isenal = 1'b0;
    model_reset();
    repeat (3) @(posedge iclk);
    #10;
    check_all("rst");
    irst_n = 1'b1;

    // single frame 1,0,1,1,0,0,1,0
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) step(pat[i], "frame");
    check("b2_msb", 32'(valor_m), 32'h0000_00B2);
    check("4d_lsb", 32'(valor_l), 32'h0000_004D);
    check("b2_pulse", 32'(valido_m), 32'h1);

    // hold for 7 bits, then complete the frame
    for (int i = 0; i < 7; i++) step(1'($urandom_range(0, 1)), "hold");
    check("hold_b2", 32'(valor_m), 32'h0000_00B2);
    step(1'($urandom_range(0, 1)), "hold_end");

    // back-to-back frames
    for (int i = 0; i < 8; i++) step(1'b1, "ones");
    check("ff_msb", 32'(valor_m), 32'h0000_00FF);
    for (int i = 0; i < 8; i++) step(1'b0, "zeros");
    check("00_msb", 32'(valor_m), 32'h0);
    check("00_pulse", 32'(valido_m), 32'h1);

    // nonzero frame, then reset mid-frame after 3 bits
    pat = 8'hCC;
    for (int i = 7; i >= 0; i--) step(pat[i], "cc");
    for (int i = 0; i < 3; i++) step(1'b1, "partial");
    reset_pulse("midrst");
    pat = 8'h55;
    for (int i = 7; i >= 0; i--) step(pat[i], "after_rst");
    check("55_msb", 32'(valor_m), 32'h0000_0055);
    check("aa_lsb", 32'(valor_l), 32'h0000_00AA);

    // randomized run with occasional resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) reset_pulse("rnd_rst");
      else step(1'($urandom_range(0, 1)), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
